// File: rtl/walk_button_sync_pkg.sv
// walk_button_sync_pkg: shared FSM encodings and default timing for the traffic-controller input conditioners
package walk_button_sync_pkg;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRESS_DB = 3'd1;
    localparam logic [2:0] HELD     = 3'd2;
    localparam logic [2:0] REL_DB   = 3'd3;
    localparam logic [2:0] LOCKOUT  = 3'd4;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int LOCKOUT_DEFAULT  = 32;
endpackage

// File: rtl/walk_button_sync_sync_chain.sv
// sync_chain: STAGES-deep flop synchroniser for an asynchronous level input
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] s;
    always_ff @(posedge clk)
        if (rst) s <= '0;
        else s <= {s[STAGES-2:0], d};
    assign q = s[STAGES-1];
endmodule

// File: rtl/walk_button_sync.sv
// walk_button_sync: synchronises, debounces and rate-limits the pedestrian button into one WR_Sync pulse per press
module walk_button_sync
    import walk_button_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_DEFAULT
) (
    input  logic clk,
    input  logic Reset,
    input  logic Walk_Btn,
    output logic WR_Sync,
    output logic Btn_Level,
    output logic Busy
);
    localparam int MAXC = DEBOUNCE_CYCLES > LOCKOUT_CYCLES ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
    // Lockout is entered with the counter cleared, so exit one count early for exactly LOCKOUT_CYCLES cycles
    localparam logic [CW-1:0] LOCK_C = CW'(LOCKOUT_CYCLES > 0 ? LOCKOUT_CYCLES - 1 : 0);
    localparam logic [2:0] AFTER_REL = LOCKOUT_CYCLES > 0 ? LOCKOUT : IDLE;
    logic btn_s;
    logic [2:0] state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pulse_n, level_n;
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(Reset),
        .d(Walk_Btn),
        .q(btn_s)
    );
    always_comb begin
        state_n = state;
        cnt_n = cnt == '1 ? cnt : cnt + 1'b1;
        pulse_n = 1'b0;
        level_n = Btn_Level;
        case (state)
            IDLE: begin
                state_n = btn_s ? PRESS_DB : IDLE;
                cnt_n = btn_s ? CW'(1) : '0;
            end
            PRESS_DB:
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n = '0;
                end else if (cnt == DEB_C) begin
                    state_n = HELD;
                    cnt_n = '0;
                    pulse_n = 1'b1;
                    level_n = 1'b1;
                end
            HELD:
                if (!btn_s) begin
                    state_n = REL_DB;
                    cnt_n = CW'(1);
                end
            REL_DB:
                if (btn_s) begin
                    state_n = HELD;
                    cnt_n = '0;
                end else if (cnt == DEB_C) begin
                    state_n = AFTER_REL;
                    cnt_n = '0;
                    level_n = 1'b0;
                end
            LOCKOUT:
                if (cnt == LOCK_C) begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
            default: begin
                state_n = IDLE;
                cnt_n = '0;
            end
        endcase
    end
    always_ff @(posedge clk)
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            WR_Sync <= 1'b0;
            Btn_Level <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            WR_Sync <= pulse_n;
            Btn_Level <= level_n;
        end
    assign Busy = state != IDLE;
endmodule

// File: tb/tb_walk_button_sync.sv
// tb_walk_button_sync: directed scenarios with hand-derived pulse, level and busy timing at default parameters
module tb_walk_button_sync;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic Walk_Btn = 1'b0;
    logic WR_Sync, Btn_Level, Busy;
    int cyc = 0, t0 = 0, checks = 0, failures = 0;
    int npulse, first_pulse, last_pulse, dbl, lvl_up, lvl_dn, busy_up, busy_dn, bad;
    logic wr_q = 1'b0, lvl_q = 1'b0, busy_q = 1'b0;
    walk_button_sync dut (
        .clk(clk),
        .Reset(Reset),
        .Walk_Btn(Walk_Btn),
        .WR_Sync(WR_Sync),
        .Btn_Level(Btn_Level),
        .Busy(Busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Event times are recorded relative to the scenario origin t0
    always @(negedge clk) begin
        if (WR_Sync) begin
            if (npulse == 0) first_pulse = cyc - t0;
            last_pulse = cyc - t0;
            npulse++;
            if (wr_q) dbl++;
        end
        if (Btn_Level && !lvl_q) lvl_up = cyc - t0;
        if (!Btn_Level && lvl_q) lvl_dn = cyc - t0;
        if (Busy && !busy_q) busy_up = cyc - t0;
        if (!Busy && busy_q) busy_dn = cyc - t0;
        wr_q = WR_Sync;
        lvl_q = Btn_Level;
        busy_q = Busy;
    end
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Leaves us at the negedge following edge t0+k-1, so a drive here is first sampled at edge t0+k
    task automatic go(input int k);
        while (cyc < t0 + k - 1) @(negedge clk);
    endtask
    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        Walk_Btn = 1'b0;
        repeat (2) @(negedge clk);
        npulse = 0; first_pulse = -1; last_pulse = -1; dbl = 0;
        lvl_up = -1; lvl_dn = -1; busy_up = -1; busy_dn = -1;
        Reset = 1'b0;
        t0 = cyc;
    endtask
    initial begin
        do_reset();
        check("rst_wr", WR_Sync, 0);
        check("rst_level", Btn_Level, 0);
        check("rst_busy", Busy, 0);
        // Clean press: release mirrors press, 110+2+16=128, then 32 lockout cycles
        go(10); Walk_Btn = 1'b1;
        go(110); Walk_Btn = 1'b0;
        go(200);
        check("clean_npulse", npulse, 1);
        check("clean_pulse_at", first_pulse, 28);
        check("clean_busy_up", busy_up, 12);
        check("clean_lvl_up", lvl_up, 28);
        check("clean_lvl_dn", lvl_dn, 128);
        check("clean_busy_dn", busy_dn, 160);
        check("clean_dbl", dbl, 0);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            go(10 + i);
            Walk_Btn = ((i / 3) % 2) == 0;
        end
        go(40); Walk_Btn = 1'b1;
        go(100); Walk_Btn = 1'b0;
        go(200);
        check("bounce_npulse", npulse, 1);
        check("bounce_pulse_at", first_pulse, 58);
        check("bounce_busy", Busy, 0);
        do_reset();
        go(10); Walk_Btn = 1'b1;
        go(20); Walk_Btn = 1'b0;
        go(60);
        check("glitch_npulse", npulse, 0);
        check("glitch_lvl_up", lvl_up, -1);
        check("glitch_busy_dn", busy_dn, 22);
        check("glitch_busy", Busy, 0);
        // Lockout spans edges 68..100; the held re-press restarts debounce at 101
        do_reset();
        go(10); Walk_Btn = 1'b1;
        go(50); Walk_Btn = 1'b0;
        go(80); Walk_Btn = 1'b1;
        go(140); Walk_Btn = 1'b0;
        go(220);
        check("lock_npulse", npulse, 2);
        check("lock_first", first_pulse, 28);
        check("lock_second", last_pulse, 117);
        check("lock_dbl", dbl, 0);
        check("lock_busy_dn", busy_dn, 190);
        do_reset();
        go(10); Walk_Btn = 1'b1;
        go(20); Reset = 1'b1;
        go(21);
        check("midrst_busy", Busy, 0);
        check("midrst_level", Btn_Level, 0);
        check("midrst_wr", WR_Sync, 0);
        go(22); Reset = 1'b0;
        go(100); Walk_Btn = 1'b0;
        go(200);
        check("midrst_npulse", npulse, 1);
        check("midrst_pulse_at", first_pulse, 40);
        do_reset();
        go(10); Walk_Btn = 1'b1;
        bad = 0;
        for (int k = 13; k <= 1011; k++) begin
            go(k);
            if (k == 1010) Walk_Btn = 1'b0;
            if (!Busy) bad++;
        end
        go(1100);
        check("long_busy_gaps", bad, 0);
        check("long_npulse", npulse, 1);
        check("long_pulse_at", first_pulse, 28);
        check("long_dbl", dbl, 0);
        check("long_busy_dn", busy_dn, 1060);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
